// File: rtl/wishbone_regfile_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_regfile_slave_pkg
// Description : Shared types for the Wishbone register-file slaves: bus FSM
//               state encoding, default bus widths and access error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package wishbone_regfile_slave_pkg;

  // Default bus geometry for slaves that do not override it
  localparam int WB_DEFAULT_DW = 32;
  localparam int WB_DEFAULT_AW = 4;

  // Bus-side request FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // Reason a request is answered with err instead of ack
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ADDR = 2'd1,
    ERR_RO   = 2'd2,
    ERR_SEL  = 2'd3
  } wb_err_t;

  // Classify a captured request; anything other than ERR_NONE leaves state untouched
  function automatic wb_err_t classify_access(input logic addr_hit,
                                              input logic ro_hit,
                                              input logic is_write,
                                              input logic any_sel);
    wb_err_t code;
    code = ERR_NONE;
    if (!addr_hit) begin
      code = ERR_ADDR;
    end else if (!any_sel) begin
      code = ERR_SEL;
    end else if (is_write && ro_hit) begin
      code = ERR_RO;
    end
    return code;
  endfunction

endpackage : wishbone_regfile_slave_pkg
`default_nettype wire

// File: rtl/wishbone_regfile_slave_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : wb_byte_merge
// Description : Combinational byte-lane merge: each output byte comes from the
//               new word when its select bit is set, else from the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_byte_merge
  import wishbone_regfile_slave_pkg::*;
#(
  parameter int DW = WB_DEFAULT_DW
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] sel,
  output logic [DW-1:0]   merged
);

  for (genvar k = 0; k < DW / 8; k++) begin : g_byte
    assign merged[k*8 +: 8] = sel[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
  end

endmodule : wb_byte_merge
`default_nettype wire

// File: rtl/wishbone_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_regfile_slave
// Description : Wishbone B4 pipelined slave fronting a NUM_REGS x DW register
//               file with byte enables, optional wait states, hardware-sourced
//               read-only registers and err responses for bad accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_regfile_slave
  import wishbone_regfile_slave_pkg::*;
#(
  parameter int                  DW          = WB_DEFAULT_DW,
  parameter int                  AW          = WB_DEFAULT_AW,
  parameter int                  NUM_REGS    = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter int                  WAIT_STATES = 0,
  parameter logic [DW-1:0]       RESET_VAL   = '0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [AW-1:0]          i_wb_addr,
  input  logic [DW-1:0]          i_wb_data,
  input  logic [DW/8-1:0]        i_wb_sel,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic                   o_wb_err,
  output logic [DW-1:0]          o_wb_data,
  output logic [NUM_REGS*DW-1:0] o_regs,
  output logic [NUM_REGS-1:0]    o_wr_pulse,
  input  logic [NUM_REGS*DW-1:0] i_ro_data
);

  localparam int         SW        = DW / 8;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_t        state, state_next;
  logic [3:0]       wait_cnt, wait_cnt_next;

  logic [AW-1:0]    req_addr;
  logic             req_we;
  logic [DW-1:0]    req_data;
  logic [SW-1:0]    req_sel;

  logic [DW-1:0]    regs [NUM_REGS];
  logic [DW-1:0]    data_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic             accept;
  logic             in_resp;
  logic             addr_hit;
  logic             ro_hit;
  logic [DW-1:0]    rw_word;
  logic [DW-1:0]    ro_word;
  logic [DW-1:0]    read_word;
  logic [DW-1:0]    merged_word;
  logic [DW-1:0]    resp_data;
  wb_err_t          err_code;
  logic             resp_err;

  // Reset masks the handshake outputs so an in-flight response is dropped at once
  assign o_wb_stall = (state != ST_IDLE) && !i_reset;
  assign accept     = (state == ST_IDLE) && i_wb_cyc && i_wb_stb && !i_reset;
  assign in_resp    = (state == ST_RESP) && !i_reset;

  // Decode the captured address into its register, RO flag and hardware value
  always_comb begin
    addr_hit = 1'b0;
    ro_hit   = 1'b0;
    rw_word  = '0;
    ro_word  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == AW'(i)) begin
        addr_hit = 1'b1;
        ro_hit   = RO_MASK[i];
        rw_word  = regs[i];
        ro_word  = i_ro_data[i*DW +: DW];
      end
    end
  end

  assign err_code  = classify_access(addr_hit, ro_hit, req_we, |req_sel);
  assign resp_err  = (err_code != ERR_NONE);
  assign read_word = ro_hit ? ro_word : rw_word;

  wb_byte_merge #(
    .DW (DW)
  ) u_merge (
    .old_word (rw_word),
    .new_word (req_data),
    .sel      (req_sel),
    .merged   (merged_word)
  );

  // Read data is live in the response cycle; writes leave the last read value on the bus
  always_comb begin
    resp_data = data_q;
    if (resp_err) begin
      resp_data = '0;
    end else if (!req_we) begin
      resp_data = read_word;
    end
  end

  assign o_wb_ack  = in_resp && !resp_err;
  assign o_wb_err  = in_resp && resp_err;
  assign o_wb_data = in_resp ? resp_data : data_q;

  // Next-state logic: count wait states, abort on cyc loss before the response
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          state_next = ST_IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Capture the request on acceptance; held stable until the response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_addr <= '0;
      req_we   <= 1'b0;
      req_data <= '0;
      req_sel  <= '0;
    end else if (accept) begin
      req_addr <= i_wb_addr;
      req_we   <= i_wb_we;
      req_data <= i_wb_data;
      req_sel  <= i_wb_sel;
    end
  end

  // Register file, read-data hold register and write-commit pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
      data_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (in_resp) begin
        data_q <= resp_data;
        if (!resp_err && req_we) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == AW'(i)) begin
              regs[i]       <= merged_word;
              wr_pulse_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_wr_pulse = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign o_regs[i*DW +: DW] = regs[i];
  end

`ifdef FORMAL
  // Handshake invariants
  a_ack_err_excl: assert property (@(posedge i_clk) !(o_wb_ack && o_wb_err));
  a_resp_stalled: assert property (@(posedge i_clk) (o_wb_ack || o_wb_err) |-> o_wb_stall);
  a_one_outstand: assert property (@(posedge i_clk) disable iff (i_reset)
                                   accept |=> o_wb_stall);
  a_resp_to_idle: assert property (@(posedge i_clk) disable iff (i_reset)
                                   (o_wb_ack || o_wb_err) |=> !o_wb_stall);
  a_resp_latency: assert property (@(posedge i_clk) disable iff (i_reset)
                                   (accept && WAIT_STATES == 0) |=> (o_wb_ack || o_wb_err));
`endif

endmodule : wishbone_regfile_slave
`default_nettype wire

// File: tb/tb_wishbone_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_regfile_slave
// Description : Two slaves (0 and 3 wait states) driven by directed and random
//               bus traffic, checked every cycle against a transaction-level
//               model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_regfile_slave;

  localparam int          N    = 12;
  localparam logic [31:0] RV0  = 32'h0000_0000;
  localparam logic [31:0] RV1  = 32'hC3C3_3C3C;
  localparam logic [N-1:0] ROM = 12'h020;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst   [2];
  logic            cyc   [2];
  logic            stb   [2];
  logic            we    [2];
  logic [3:0]      addr  [2];
  logic [31:0]     wdat  [2];
  logic [3:0]      sel   [2];
  logic [N*32-1:0] ro_data;

  logic            stall_o [2];
  logic            ack_o   [2];
  logic            err_o   [2];
  logic [31:0]     rdat    [2];
  logic [N-1:0]    pulse_o [2];
  logic [N*32-1:0] regs_o  [2];

  int checks   = 0;
  int failures = 0;
  int pulse3_cnt = 0;
  int resp_cnt [2] = '{0, 0};

  wishbone_regfile_slave #(
    .DW(32), .AW(4), .NUM_REGS(N), .RO_MASK(ROM), .WAIT_STATES(0), .RESET_VAL(RV0)
  ) u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_addr(addr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]), .o_wb_stall(stall_o[0]),
    .o_wb_ack(ack_o[0]), .o_wb_err(err_o[0]), .o_wb_data(rdat[0]), .o_regs(regs_o[0]),
    .o_wr_pulse(pulse_o[0]), .i_ro_data(ro_data)
  );

  wishbone_regfile_slave #(
    .DW(32), .AW(4), .NUM_REGS(N), .RO_MASK(ROM), .WAIT_STATES(3), .RESET_VAL(RV1)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_addr(addr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]), .o_wb_stall(stall_o[1]),
    .o_wb_ack(ack_o[1]), .o_wb_err(err_o[1]), .o_wb_data(rdat[1]), .o_regs(regs_o[1]),
    .o_wr_pulse(pulse_o[1]), .i_ro_data(ro_data)
  );

  task automatic chk(input string name, input int d, input logic [N*32-1:0] got,
                     input logic [N*32-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", name, d, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]     m_regs  [2][N];
  logic            m_busy  [2];
  int              m_age   [2];
  logic            m_pwe   [2];
  logic [3:0]      m_paddr [2];
  logic [3:0]      m_psel  [2];
  logic [31:0]     m_pdata [2];
  logic [31:0]     m_last  [2];
  logic [N-1:0]    m_pulse [2];
  bit              m_valid [2] = '{1'b0, 1'b0};

  int              ws;
  bit              e_resp, e_bad;
  logic [31:0]     e_data;
  logic [N*32-1:0] e_regs;
  int              pa;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ws = (d == 0) ? 0 : 3;
      if (ack_o[d] || err_o[d]) resp_cnt[d]++;
      if (rst[d]) begin
        chk("rst_ack",   d, N*32'(ack_o[d]),   '0);
        chk("rst_err",   d, N*32'(err_o[d]),   '0);
        chk("rst_stall", d, N*32'(stall_o[d]), '0);
        m_busy[d]  = 1'b0;
        m_last[d]  = '0;
        m_pulse[d] = '0;
        for (int i = 0; i < N; i++) m_regs[d][i] = (d == 0) ? RV0 : RV1;
        m_valid[d] = 1'b1;
      end else if (m_valid[d]) begin
        if (d == 0 && pulse_o[0][3]) pulse3_cnt++;
        pa     = int'(m_paddr[d]);
        e_resp = m_busy[d] && (m_age[d] == ws + 1);
        e_bad  = (pa >= N) || (m_psel[d] == 4'd0) || (m_pwe[d] && pa < N && ROM[pa % N]);
        e_data = m_last[d];
        if (e_resp) begin
          if (e_bad)             e_data = '0;
          else if (!m_pwe[d])    e_data = ROM[pa] ? ro_data[pa*32 +: 32] : m_regs[d][pa];
        end
        for (int i = 0; i < N; i++) e_regs[i*32 +: 32] = m_regs[d][i];
        chk("ack",   d, N*32'(ack_o[d]),   N*32'(e_resp && !e_bad));
        chk("err",   d, N*32'(err_o[d]),   N*32'(e_resp && e_bad));
        chk("stall", d, N*32'(stall_o[d]), N*32'(m_busy[d]));
        chk("rdata", d, N*32'(rdat[d]),    N*32'(e_data));
        chk("pulse", d, N*32'(pulse_o[d]), N*32'(m_pulse[d]));
        chk("regs",  d, regs_o[d],         e_regs);
        // advance model to the next cycle
        m_pulse[d] = '0;
        m_last[d]  = e_data;
        if (e_resp) begin
          m_busy[d] = 1'b0;
          if (!e_bad && m_pwe[d]) begin
            for (int k = 0; k < 4; k++)
              if (m_psel[d][k]) m_regs[d][pa][k*8 +: 8] = m_pdata[d][k*8 +: 8];
            m_pulse[d][pa] = 1'b1;
          end
        end else if (m_busy[d]) begin
          if (!cyc[d]) m_busy[d] = 1'b0;
          else         m_age[d]++;
        end else if (cyc[d] && stb[d]) begin
          m_busy[d]  = 1'b1;
          m_age[d]   = 1;
          m_pwe[d]   = we[d];
          m_paddr[d] = addr[d];
          m_psel[d]  = sel[d];
          m_pdata[d] = wdat[d];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int d, input bit w, input logic [3:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input bit hold, input int abort_at,
                      output bit got_ack, output bit got_err, output logic [31:0] rd,
                      output int lat, output int nstall);
    int g;
    bit done;
    got_ack = 0; got_err = 0; rd = '0; lat = 0; nstall = 0; done = 0; g = 0;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = dat; sel[d] = s;
    @(negedge clk);
    while (stall_o[d] && g < 20) begin
      @(negedge clk);
      g++;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !hold) stb[d] = 1'b0;
      if (c == abort_at) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
      @(negedge clk);
      if (stall_o[d]) nstall++;
      if (ack_o[d] || err_o[d]) begin
        got_ack = ack_o[d]; got_err = err_o[d]; rd = rdat[d]; lat = c; done = 1;
        break;
      end
      if (abort_at != 0 && c >= abort_at + 3) break;
    end
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    checks++;
    if (!done && abort_at == 0) begin
      failures++;
      $display("FAIL resp_timeout dut%0d got=none exp=ack_or_err", d);
    end
  endtask

  bit          ga, ge;
  logic [31:0] rd;
  int          lat, nst, p0, r0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; wdat[d] = '0; sel[d] = '0;
    end
    ro_data = '0;
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("reset_ack",   0, N*32'(ack_o[0]),   '0);
    chk("reset_stall", 1, N*32'(stall_o[1]), '0);
    chk("reset_rdata", 0, N*32'(rdat[0]),    '0);
    chk("reset_pulse", 1, N*32'(pulse_o[1]), '0);
    chk("reset_regs0", 0, regs_o[0], {N{RV0}});
    chk("reset_regs1", 1, regs_o[1], {N{RV1}});

    // read after reset
    xact(0, 0, 4'd0, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t1_ack", 0, N*32'(ga), N*32'(1)); chk("t1_err", 0, N*32'(ge), '0);
    chk("t1_lat", 0, N*32'(lat), N*32'(1)); chk("t1_data", 0, N*32'(rd), N*32'(RV0));

    // byte-enabled write then read back
    p0 = pulse3_cnt;
    xact(0, 1, 4'd3, 32'hDEADBEEF, 4'b0101, 0, 0, ga, ge, rd, lat, nst);
    chk("t2_wack", 0, N*32'(ga), N*32'(1));
    repeat (2) @(negedge clk);
    chk("t2_pulse_once", 0, N*32'(pulse3_cnt - p0), N*32'(1));
    xact(0, 0, 4'd3, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t2_data", 0, N*32'(rd), N*32'(32'h00AD00EF));

    // out-of-range address and empty byte select
    xact(0, 1, 4'd12, 32'h12345678, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t3_werr", 0, N*32'({ga, ge}), N*32'(2'b01)); chk("t3_lat", 0, N*32'(lat), N*32'(1));
    xact(0, 0, 4'd12, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t3_rerr", 0, N*32'({ga, ge}), N*32'(2'b01)); chk("t3_rdata", 0, N*32'(rd), '0);
    xact(0, 1, 4'd1, 32'hFFFFFFFF, 4'h0, 0, 0, ga, ge, rd, lat, nst);
    chk("t3_sel0", 0, N*32'({ga, ge}), N*32'(2'b01));

    // read-only register
    ro_data[5*32 +: 32] = 32'h0000_1234;
    xact(0, 0, 4'd5, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t4_ro_read", 0, N*32'({ga, ge, rd}), N*32'({2'b10, 32'h1234}));
    xact(0, 1, 4'd5, 32'hAAAA5555, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t4_ro_write", 0, N*32'({ga, ge}), N*32'(2'b01));

    // wait states with stb held through the stall
    xact(1, 0, 4'd2, 32'h0, 4'hF, 1, 0, ga, ge, rd, lat, nst);
    chk("t5_ack", 1, N*32'(ga), N*32'(1)); chk("t5_lat", 1, N*32'(lat), N*32'(4));
    chk("t5_nstall", 1, N*32'(nst), N*32'(4)); chk("t5_data", 1, N*32'(rd), N*32'(RV1));
    r0 = resp_cnt[1];
    repeat (8) @(negedge clk);
    chk("t5_no_dup", 1, N*32'(resp_cnt[1] - r0), '0);

    // cyc dropped in WAIT
    xact(1, 1, 4'd4, 32'h0F0F0F0F, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    r0 = resp_cnt[1];
    xact(1, 1, 4'd4, 32'hFFFFFFFF, 4'hF, 0, 2, ga, ge, rd, lat, nst);
    chk("t6_abort_resp", 1, N*32'(resp_cnt[1] - r0), '0);
    xact(1, 0, 4'd4, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t6_abort_reg", 1, N*32'(rd), N*32'(32'h0F0F0F0F));

    // reset in WAIT
    xact(1, 1, 4'd6, 32'h11112222, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    r0 = resp_cnt[1];
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd4; wdat[1] = 32'h77777777; sel[1] = 4'hF;
    @(posedge clk); #1 stb[1] = 1'b0;
    @(posedge clk); #1 rst[1] = 1'b1;
    @(posedge clk); #1 rst[1] = 1'b0; cyc[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_rst_resp", 1, N*32'(resp_cnt[1] - r0), '0);
    xact(1, 0, 4'd6, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t6_rst_reg6", 1, N*32'(rd), N*32'(RV1));
    xact(1, 0, 4'd4, 32'h0, 4'hF, 0, 0, ga, ge, rd, lat, nst);
    chk("t6_rst_reg4", 1, N*32'(rd), N*32'(RV1));

    // randomized traffic, checked by the model every cycle
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        logic [3:0] ra, rs;
        int ab;
        for (int i = 0; i < N; i++) ro_data[i*32 +: 32] = $urandom;
        ra = ($urandom % 8 == 0) ? 4'(12 + $urandom % 4) : 4'($urandom % 12);
        rs = ($urandom % 10 == 0) ? 4'h0 : 4'($urandom % 16);
        ab = (d == 1 && $urandom % 5 == 0) ? 1 + int'($urandom % 4) : 0;
        xact(d, 1'($urandom % 2), ra, $urandom, rs, 1'($urandom % 2), ab, ga, ge, rd, lat, nst);
        repeat ($urandom % 3) @(posedge clk);
      end
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wishbone_regfile_slave
`default_nettype wire
